// File: rtl/pixel_frame_scanner_pkg.sv
// Purpose : shared LCD colour constants, geometry and pixel type for the MSP2807 path.
// Latency : n/a (declarations only).
// Backpressure : n/a.
// Contents: rgb565_t, MSP_* RGB565 colours, MSP_BG_DEFAULT, MSP_H_RES/MSP_V_RES.
package pixel_frame_scanner_pkg;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t MSP_BLACK   = 16'h0000;
  localparam rgb565_t MSP_WHITE   = 16'hFFFF;
  localparam rgb565_t MSP_RED     = 16'hF800;
  localparam rgb565_t MSP_GREEN   = 16'h07E0;
  localparam rgb565_t MSP_BLUE    = 16'h001F;
  localparam rgb565_t MSP_YELLOW  = 16'hFFE0;

  // Colour shown wherever no overlay claims the pixel.
  localparam rgb565_t MSP_BG_DEFAULT = MSP_WHITE;

  // Panel geometry in landscape orientation.
  localparam int MSP_H_RES = 320;
  localparam int MSP_V_RES = 240;

endpackage

// File: rtl/pixel_frame_scanner_if.sv
// Purpose : RGB565 pixel stream from the frame scanner to the SPI/LCD driver.
// Latency : n/a (wires only).
// Backpressure : word is held while pix_valid && !pix_ready.
// Signals: pix_data (RGB565), pix_valid, pix_first (word is pixel 0,0), pix_ready.
//   master = scanner side, slave = LCD driver side.
interface pixel_frame_scanner_if;
  import pixel_frame_scanner_pkg::*;

  rgb565_t pix_data;
  logic    pix_valid;
  logic    pix_first;
  logic    pix_ready;

  modport master (output pix_data, output pix_valid, output pix_first, input pix_ready);
  modport slave  (input pix_data, input pix_valid, input pix_first, output pix_ready);

endinterface

// File: rtl/pixel_frame_scanner_layer_priority_mux.sv
// Purpose : pick one colour from LAYERS overlay inputs, lowest active index wins.
// Latency : combinational.
// Backpressure : none; caller must hold inputs stable while stalled.
// Ports: layer_pixel[16*i+:16] / layer_active[i] per layer, bg_colour fallback,
//   colour = selected RGB565 word.
module layer_priority_mux
  import pixel_frame_scanner_pkg::*;
#(
  parameter int LAYERS = 4
) (
  input  logic [16*LAYERS-1:0] layer_pixel,
  input  logic [LAYERS-1:0]    layer_active,
  input  rgb565_t              bg_colour,
  output rgb565_t              colour
);

  // Walk from the lowest-priority layer upward so layer 0 is applied last
  // and therefore overrides everything else.
  always_comb begin
    colour = bg_colour;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (layer_active[i]) begin
        colour = layer_pixel[16*i +: 16];
      end
    end
  end

endmodule

// File: rtl/pixel_frame_scanner.sv
// Purpose : raster walker + overlay compositor streaming one RGB565 frame to the LCD.
// Latency : coordinates on x_pixel/y_pixel in cycle n appear on pix_data in cycle n+1.
// Backpressure : pix_ready low with a pending word freezes pix_data, pix_first, x/y.
// Ports: clk, rst (async, active high), start (honoured in IDLE), busy, frame_done
//   (1-cycle pulse), en/x_pixel/y_pixel to generators, layer_pixel/layer_active
//   from generators, pix (master side of the pixel stream to the LCD driver).
module pixel_frame_scanner
  import pixel_frame_scanner_pkg::*;
#(
  parameter int      H_RES     = MSP_H_RES,
  parameter int      V_RES     = MSP_V_RES,
  parameter int      LAYERS    = 4,
  parameter rgb565_t BG_COLOUR = MSP_BG_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  en,
  output logic [8:0]            x_pixel,
  output logic [7:0]            y_pixel,
  input  logic [16*LAYERS-1:0]  layer_pixel,
  input  logic [LAYERS-1:0]     layer_active,
  pixel_frame_scanner_if.master pix
);

  generate
    if (H_RES < 1 || H_RES > 512 || V_RES < 1 || V_RES > 256) begin : g_bad_geometry
      $error("pixel_frame_scanner: H_RES must be 1..512 and V_RES 1..256");
    end
  endgenerate

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [8:0] X_LAST = 9'(H_RES - 1);
  localparam logic [7:0] Y_LAST = 8'(V_RES - 1);

  logic [1:0] state;
  rgb565_t    composed;
  logic       adv;
  logic       hs;
  logic       x_wrap;
  logic       at_last;
  logic       at_origin;

  layer_priority_mux #(.LAYERS(LAYERS)) u_mux (
    .layer_pixel  (layer_pixel),
    .layer_active (layer_active),
    .bg_colour    (BG_COLOUR),
    .colour       (composed)
  );

  assign hs        = pix.pix_valid && pix.pix_ready;
  // The output register can take a new word when empty or being drained this edge.
  assign adv       = (state == ST_SCAN) && (!pix.pix_valid || pix.pix_ready);
  assign x_wrap    = (x_pixel == X_LAST);
  assign at_last   = x_wrap && (y_pixel == Y_LAST);
  assign at_origin = (x_pixel == 9'd0) && (y_pixel == 8'd0);

  assign busy = (state != ST_IDLE);
  assign en   = (state == ST_SCAN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE:  if (start) state <= ST_SCAN;
        ST_SCAN:  if (adv && at_last) state <= ST_DRAIN;
        ST_DRAIN: begin
          // Only the final word can be pending here; its acceptance ends the frame.
          if (hs) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
          end
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Counters step only with adv, so they stay frozen under backpressure and
  // end the frame parked at (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_pixel <= 9'd0;
      y_pixel <= 8'd0;
    end else if (adv) begin
      if (x_wrap) begin
        x_pixel <= 9'd0;
        y_pixel <= (y_pixel == Y_LAST) ? 8'd0 : y_pixel + 8'd1;
      end else begin
        x_pixel <= x_pixel + 9'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix.pix_data  <= 16'h0000;
      pix.pix_valid <= 1'b0;
      pix.pix_first <= 1'b0;
    end else if (adv) begin
      pix.pix_data  <= composed;
      pix.pix_valid <= 1'b1;
      pix.pix_first <= at_origin;
    end else if (hs) begin
      pix.pix_valid <= 1'b0;
      pix.pix_first <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_frame_scanner.sv
// Purpose : directed scoreboard bench for pixel_frame_scanner on a 320x8 raster.
// Latency : n/a.
// Backpressure : bench drives pix_ready (always, random, or a targeted stall).
module tb_pixel_frame_scanner;
  import pixel_frame_scanner_pkg::*;

  localparam int H = 320;
  localparam int V = 8;
  localparam int L = 4;
  localparam int N = H * V;
  localparam int BUDGET = 20000;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           busy;
  logic           frame_done;
  logic           en;
  logic [8:0]     x_pixel;
  logic [7:0]     y_pixel;
  logic [16*L-1:0] layer_pixel;
  logic [L-1:0]   layer_active;
  int             gen_mode;

  int n_assert = 0;
  int n_fail   = 0;
  logic [16:0] sb_q[$];

  always #5 clk = ~clk;

  pixel_frame_scanner_if pif ();

  pixel_frame_scanner #(
    .H_RES(H), .V_RES(V), .LAYERS(L), .BG_COLOUR(MSP_WHITE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .frame_done   (frame_done),
    .en           (en),
    .x_pixel      (x_pixel),
    .y_pixel      (y_pixel),
    .layer_pixel  (layer_pixel),
    .layer_active (layer_active),
    .pix          (pif)
  );

  // Overlay generator models: pure functions of the coordinates.
  function automatic logic [15:0] layer_pix(input int mode, input int i, input int x, input int y);
    case (mode)
      1: case (i)
           0:       return 16'hF800;
           1:       return 16'h001F;
           2:       return 16'h07E0;
           default: return 16'hFFE0;
         endcase
      2: return {2'(i), 7'(x), 7'(y)};
      default: return 16'h1234 + 16'(i);
    endcase
  endfunction

  function automatic logic layer_act(input int mode, input int i, input int x, input int y);
    int k;
    k = (x * 5 + y * 3) & 15;
    case (mode)
      1: return (i == 0) ? (x == 10 && y == 5) : 1'b1;
      2: return 1'(k >> i);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] exp_word(input int mode, input int x, input int y);
    for (int i = 0; i < L; i++) begin
      if (layer_act(mode, i, x, y)) return layer_pix(mode, i, x, y);
    end
    return 16'hFFFF;
  endfunction

  always_comb begin
    layer_pixel  = '0;
    layer_active = '0;
    for (int i = 0; i < L; i++) begin
      layer_pixel[16*i +: 16] = layer_pix(gen_mode, i, int'(x_pixel), int'(y_pixel));
      layer_active[i]         = layer_act(gen_mode, i, int'(x_pixel), int'(y_pixel));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(frame_done), 32'd0);
    chk({tag, "_en"},    32'(en), 32'd0);
    chk({tag, "_x"},     32'(x_pixel), 32'd0);
    chk({tag, "_y"},     32'(y_pixel), 32'd0);
    chk({tag, "_valid"}, 32'(pif.pix_valid), 32'd0);
    chk({tag, "_first"}, 32'(pif.pix_first), 32'd0);
    chk({tag, "_data"},  32'(pif.pix_data), 32'h0000);
  endtask

  // Entered and left at a sample point (1 time unit after a rising edge).
  // rmode: 0 ready always high, 1 random ready, 2 seven-cycle stall at (H-1,0).
  task automatic run_frame(input int mode, input int rmode, input int abort_at,
                           input int mid_start, input string tag);
    int cyc, got, stall_n;
    bit wrap_pend, finished;
    logic pv, pr;
    logic pf;
    logic [15:0] pd;
    logic [8:0] px;
    logic [7:0] py;
    logic [16:0] e;
    cyc = 0; got = 0; stall_n = 0; wrap_pend = 0; finished = 0;
    pv = 1'b0; pr = 1'b0; pf = 1'b0; pd = '0; px = '0; py = '0;
    gen_mode = mode;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        sb_q.push_back({(x == 0 && y == 0), exp_word(mode, x, y)});
    start = 1'b1;
    pif.pix_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, "_en_after_start"}, 32'(en), 32'd1);
    while (!finished && cyc < BUDGET) begin
      if (pv && !pr) begin
        chk({tag, "_stall_data"},  32'(pif.pix_data), 32'(pd));
        chk({tag, "_stall_first"}, 32'(pif.pix_first), 32'(pf));
        chk({tag, "_stall_valid"}, 32'(pif.pix_valid), 32'd1);
        chk({tag, "_stall_x"},     32'(x_pixel), 32'(px));
        chk({tag, "_stall_y"},     32'(y_pixel), 32'(py));
      end
      chk({tag, "_x_range"}, 32'(int'(x_pixel) < H), 32'd1);
      chk({tag, "_y_range"}, 32'(int'(y_pixel) < V), 32'd1);
      if (wrap_pend) begin
        chk({tag, "_wrap_x"}, 32'(x_pixel), 32'd0);
        chk({tag, "_wrap_y"}, 32'(y_pixel), 32'd1);
        wrap_pend = 0;
      end
      if (frame_done) begin
        finished = 1;
        chk({tag, "_word_count"}, 32'(got), 32'(N));
        chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        if (rmode == 0) chk({tag, "_done_cycle"}, 32'(cyc), 32'(N + 1));
      end else begin
        start = (mid_start != 0 && cyc == 200) ? 1'b1 : 1'b0;
        if (rmode == 1) begin
          pr = 1'($urandom_range(0, 1));
        end else if (rmode == 2 && int'(x_pixel) == H - 1 && y_pixel == 8'd0 &&
                     pif.pix_valid && stall_n < 7) begin
          pr = 1'b0;
          stall_n++;
        end else begin
          if (stall_n == 7) begin
            wrap_pend = 1;
            stall_n = 8;
          end
          pr = 1'b1;
        end
        pif.pix_ready = pr;
        if (pif.pix_valid && pr) begin
          chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
          e = (sb_q.size() > 0) ? sb_q.pop_front() : 17'h0;
          chk({tag, "_data"},  32'(pif.pix_data), 32'(e[15:0]));
          chk({tag, "_first"}, 32'(pif.pix_first), 32'(e[16]));
          got++;
          if (abort_at > 0 && got == abort_at) return;
        end
        pv = pif.pix_valid; pd = pif.pix_data; pf = pif.pix_first;
        px = x_pixel; py = y_pixel;
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    chk({tag, "_frame_done_seen"}, 32'(finished), 32'd1);
    if (rmode == 2) chk({tag, "_stall_done"}, 32'(stall_n), 32'd8);
  endtask

  task automatic post_done(input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_pulse_width"}, 32'(frame_done), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_valid_idle"}, 32'(pif.pix_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    gen_mode = 0;
    pif.pix_ready = 1'b0;
    #12;
    chk_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);

    // All layers idle: every word is background.
    run_frame(0, 0, 0, 0, "t1");
    post_done("t1");

    // Layer 0 only at (10,5), layer 1 everywhere.
    run_frame(1, 0, 0, 0, "t2");
    post_done("t2");

    // Random backpressure with a mixed priority pattern.
    run_frame(2, 1, 0, 0, "t3");
    post_done("t3");

    // Long stall right at the end of line 0.
    run_frame(2, 2, 0, 0, "t4");
    post_done("t4");

    // start mid-frame is ignored; start right after frame_done begins a new frame.
    run_frame(2, 0, 0, 1, "t5a");
    run_frame(0, 0, 0, 0, "t5b");
    post_done("t5b");

    // Asynchronous reset with a word pending at pixel 1000.
    run_frame(1, 0, 1000, 0, "t6");
    chk("t6_valid_before_rst", 32'(pif.pix_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_reset_values("t6_async");
    @(posedge clk); #1;
    chk("t6_no_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    chk("t6_no_done_after", 32'(frame_done), 32'd0);
    run_frame(1, 0, 0, 0, "t6b");
    post_done("t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
